// File: rtl/tile_draw_scheduler_if.sv
// Glyph-drawer handshake between the redraw scheduler (master) and the shared
// glyph drawer / plot mux (slave).
interface tile_draw_scheduler_if;
  logic       glyph_start;
  logic [3:0] glyph_id;
  logic [7:0] x_origin;
  logic [6:0] y_origin;
  logic       glyph_done;

  modport master (
    output glyph_start, glyph_id, x_origin, y_origin,
    input  glyph_done
  );

  modport slave (
    input  glyph_start, glyph_id, x_origin, y_origin,
    output glyph_done
  );
endinterface

// File: rtl/tile_draw_scheduler.sv
// Redraw sequencer for the 4x4 sliding-puzzle board: walks the 16 positions,
// launches the glyph drawer for changed (or all) tiles and waits for each glyph.
module tile_draw_scheduler #(
  parameter logic [7:0]  X0      = 8'd0,
  parameter logic [6:0]  Y0      = 7'd0,
  parameter logic [5:0]  PITCH   = 6'd30,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         force_all,
  input  logic [63:0]                  board,
  tile_draw_scheduler_if.master        glyph,
  output logic                         busy,
  output logic                         done,
  output logic [4:0]                   tiles_drawn,
  output logic                         timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LAUNCH,
    WAIT,
    NEXT,
    FINISH
  } state_t;

  localparam int unsigned    CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, nextState;
  logic [63:0]   snap;
  logic [63:0]   shadow;
  logic          shadowValid;
  logic          frc;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  logic [3:0]    idReg;
  logic [7:0]    xReg;
  logic [6:0]    yReg;
  logic          glyphStart;
  logic [3:0]    snapTile;
  logic [3:0]    shadowTile;
  logic          dirty;
  logic          waitExpired;

  assign snapTile    = snap[{idx, 2'b00} +: 4];
  assign shadowTile  = shadow[{idx, 2'b00} +: 4];
  assign dirty       = frc | ~shadowValid | (snapTile != shadowTile);
  assign waitExpired = (cnt == CNT_LAST);

  assign glyph.glyph_start = glyphStart;
  assign glyph.glyph_id    = idReg;
  assign glyph.x_origin    = xReg;
  assign glyph.y_origin    = yReg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState  = state;
    glyphStart = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) nextState = SCAN;
      SCAN:    nextState = dirty ? LAUNCH : NEXT;
      LAUNCH: begin
        glyphStart = 1'b1;
        nextState  = WAIT;
      end
      WAIT:    if (glyph.glyph_done || waitExpired) nextState = NEXT;
      NEXT:    nextState = (idx == 4'd15) ? FINISH : SCAN;
      FINISH: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap        <= '0;
      shadow      <= '0;
      shadowValid <= 1'b0;
      frc         <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
      idReg       <= '0;
      xReg        <= '0;
      yReg        <= '0;
      busy        <= 1'b0;
      tiles_drawn <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap        <= board;
            frc         <= force_all;
            tiles_drawn <= '0;
            timeout_err <= 1'b0;
            idx         <= '0;
            busy        <= 1'b1;
          end
        end
        SCAN: begin
          // Drawer outputs are loaded here so they are already valid in LAUNCH.
          if (dirty) begin
            idReg <= snapTile;
            xReg  <= X0 + 8'(idx[1:0]) * 8'(PITCH);
            yReg  <= Y0 + 7'(idx[3:2]) * 7'(PITCH);
          end
        end
        WAIT: begin
          if (glyph.glyph_done) begin
            shadow[{idx, 2'b00} +: 4] <= snapTile;
            tiles_drawn               <= tiles_drawn + 5'd1;
            cnt                       <= '0;
          end else if (waitExpired) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        NEXT: begin
          if (idx == 4'd15) begin
            if (!timeout_err) shadowValid <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        FINISH:  busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
